wdg_window_monitor: RTL and testbench
=====================================

// Module: wdg_window_monitor
// PURPOSE
//  Downstream consumer of the watchdog toggle flip-flop output. Watches the
//  toggling heartbeat, measures the interval between toggles, counts missed
//  heartbeats and raises a sticky alarm when MISS_LIMIT consecutive timeouts
//  occur. Sits between the toggle stage and the system fault/reset controller.
// PARAMETERS
//  CNT_W      16    width of interval counter and period output
//  TIMEOUT    1000  cycles without a toggle that count as one miss (2..2^CNT_W-1)
//  MISS_LIMIT 3     consecutive misses that raise alarm (1..2^MISS_W-1)
//  MISS_W     2     width of missCount
//  MIN_GAP    10    minimum legal toggle interval; used only with WDG_WINDOW_EN
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  rst          in   1        synchronous, active-low reset
//  wdgIn        in   1        heartbeat toggle from the T flip-flop stage (same clk)
//  en           in   1        monitor enable
//  clrAlarm     in   1        one-cycle request to clear sticky alarm
//  alarm        out  1        sticky fault flag, registered
//  cause        out  2        01 timeout, 10 early toggle, 00 none
//  missCount    out  MISS_W   consecutive misses since last valid toggle
//  period       out  CNT_W    last measured toggle interval, cycles
//  periodValid  out  1        one-cycle pulse when period updates
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state=IDLE, cnt=0, wdgPrev=0, alarm=0, cause=00,
//    missCount=0, period=0, periodValid=0. Reset overrides everything, any state.
//  - Edge detect: wdgPrev<=wdgIn every cycle in all states; edge = wdgIn^wdgPrev.
//    Both toggle directions count. Tracking in IDLE prevents false edge on enable.
//  - FSM: IDLE, ARM, RUN, ALARM.
//    IDLE: cnt held 0. en=1 -> ARM.
//    ARM: cnt++ per cycle; first edge -> RUN, cnt=0, no period reported.
//    RUN: cnt++ per cycle; edge -> cnt=0, missCount=0, period=cnt+1, periodValid=1.
//    ARM/RUN timeout: no edge and cnt==TIMEOUT-1 -> cnt=0, missCount++ ; if new
//      missCount==MISS_LIMIT -> ALARM, alarm=1, cause=01 next cycle.
//    ALARM: cnt held 0; alarm/cause/missCount frozen; edges ignored.
//      clrAlarm=1 -> alarm=0, cause=00, missCount=0, then ARM if en else IDLE.
//    en=0 in ARM/RUN -> IDLE next cycle, cnt=0, missCount=0; alarm untouched.
//  - Simultaneous edge and timeout in same cycle: edge wins, no miss.
//  - clrAlarm in same cycle a new fault is detected (ARM/RUN): fault wins.
//  - clrAlarm outside ALARM: no effect.
//  - Latency: alarm, period, periodValid registered, visible 1 cycle after the
//    detecting cycle. periodValid never asserted in ARM, IDLE or ALARM.
//  - cnt saturates never: TIMEOUT<2^CNT_W guarantees wrap is impossible.
// CONFIGURATION
//  WDG_WINDOW_EN defined: in RUN, an edge with cnt+1 < MIN_GAP is an early
//    fault -> ALARM, alarm=1, cause=10, period=cnt+1, no periodValid pulse.
//  WDG_WINDOW_EN undefined: no early check, MIN_GAP ignored, cause[1] tied 0,
//    any RUN edge is a valid heartbeat.
// STRUCTURE
//  Shared package wdg_pkg: state encoding localparams (IDLE=0,ARM=1,RUN=2,
//    ALARM=3), cause codes CAUSE_NONE/CAUSE_TIMEOUT/CAUSE_EARLY.
//  One sub-module: wdg_edge_det (wdgPrev register + XOR, reset to 0).
//  FSM, counter and outputs in top level.
// TESTING  (CNT_W=8, TIMEOUT=20, MISS_LIMIT=3, MISS_W=2, MIN_GAP=4)
//  1 rst=0 two cycles, wdgIn=1 -> all outputs 0, state IDLE, no edge on release.
//  2 en=1, toggle wdgIn every 10 cycles x8 -> periodValid pulses 7x, period=10,
//    alarm=0, missCount=0.
//  3 after entering RUN stop toggling -> missCount=1 @20, 2 @40, alarm=1 cause=01
//    one cycle after 60th idle cycle; holds while toggles resume.
//  4 pulse clrAlarm with en=1 -> alarm=0 cause=00 missCount=0, state ARM; toggle
//    exactly on cycle 20 of an interval -> no miss (edge wins).
//  5 WDG_WINDOW_EN: toggles 2 cycles apart in RUN -> alarm=1, cause=10, period=2;
//    rebuilt without macro, same stimulus -> period=2, periodValid=1, alarm=0.
//  6 rst=0 while ALARM set mid-run -> all outputs 0 next cycle; en=0 mid-RUN with
//    missCount=2 -> IDLE, missCount=0, alarm unchanged.

Source files
------------

// File: rtl/wdg_pkg.sv
// Shared definitions for the watchdog window monitor: FSM state encoding
// and the fault cause codes reported on the cause output.
package wdg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    ALARM = 2'd3
  } wdg_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_EARLY   = 2'b10;

endpackage

// File: rtl/wdg_edge_det.sv
// Heartbeat edge detector: remembers the previous heartbeat level and flags
// any change, rising or falling. The previous level is tracked in every
// monitor state so enabling the monitor never produces a spurious edge.
module wdg_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic wdgIn,
  output logic toggle
);

  logic wdg_prev;

  // Track the heartbeat level one cycle late; cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdg_prev <= 1'b0;
    end else begin
      wdg_prev <= wdgIn;
    end
  end

  assign toggle = wdgIn ^ wdg_prev;

endmodule

// File: rtl/wdg_window_monitor.sv
// Watchdog window monitor: measures the interval between heartbeat toggles,
// counts consecutive timeouts and raises a sticky alarm after MISS_LIMIT of
// them. Defining WDG_WINDOW_EN additionally flags toggles that arrive sooner
// than MIN_GAP cycles after the previous one as an early fault.
module wdg_window_monitor
  import wdg_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int MISS_LIMIT = 3,
  parameter int MISS_W     = 2,
  parameter int MIN_GAP    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wdgIn,
  input  logic              en,
  input  logic              clrAlarm,
  output logic              alarm,
  output logic [1:0]        cause,
  output logic [MISS_W-1:0] missCount,
  output logic [CNT_W-1:0]  period,
  output logic              periodValid
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

`ifdef WDG_WINDOW_EN
  localparam logic [CNT_W-1:0]  GAP_MIN  = CNT_W'(MIN_GAP);
`else
  logic unused_min_gap;
  assign unused_min_gap = (MIN_GAP != 0);
`endif

  wdg_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [MISS_W-1:0] miss_inc;
  logic              toggle;

  wdg_edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .wdgIn  (wdgIn),
    .toggle (toggle)
  );

  // The interval just measured is cnt+1 because cnt starts at 0 on the edge cycle.
  assign cnt_inc  = cnt + 1'b1;
  assign miss_inc = missCount + 1'b1;

  // Monitor FSM with interval counter and registered outputs; an edge beats a
  // simultaneous timeout, and a detected fault beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      alarm       <= 1'b0;
      cause       <= CAUSE_NONE;
      missCount   <= '0;
      period      <= '0;
      periodValid <= 1'b0;
    end else begin
      periodValid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state <= ARM;
          end
        end

        ARM, RUN: begin
          if (!en) begin
            state     <= IDLE;
            cnt       <= '0;
            missCount <= '0;
          end else if (toggle) begin
            cnt <= '0;
            if (state == ARM) begin
              state <= RUN;
`ifdef WDG_WINDOW_EN
            end else if (cnt_inc < GAP_MIN) begin
              state  <= ALARM;
              alarm  <= 1'b1;
              cause  <= CAUSE_EARLY;
              period <= cnt_inc;
`endif
            end else begin
              missCount   <= '0;
              period      <= cnt_inc;
              periodValid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            missCount <= miss_inc;
            if (miss_inc == MISS_MAX) begin
              state <= ALARM;
              alarm <= 1'b1;
              cause <= CAUSE_TIMEOUT;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        ALARM: begin
          cnt <= '0;
          if (clrAlarm) begin
            alarm     <= 1'b0;
            cause     <= CAUSE_NONE;
            missCount <= '0;
            state     <= en ? ARM : IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wdg_window_monitor.sv
// Directed testbench for wdg_window_monitor (CNT_W=8, TIMEOUT=20,
// MISS_LIMIT=3, MISS_W=2, MIN_GAP=4). Expectations for the early-toggle
// step follow WDG_WINDOW_EN when the bench is built with that macro.
module tb_wdg_window_monitor;

  logic       clk;
  logic       rst;
  logic       wdgIn;
  logic       en;
  logic       clrAlarm;
  logic       alarm;
  logic [1:0] cause;
  logic [1:0] missCount;
  logic [7:0] period;
  logic       periodValid;

  int vectors;
  int miscompares;
  int pulses;

  wdg_window_monitor #(
    .CNT_W      (8),
    .TIMEOUT    (20),
    .MISS_LIMIT (3),
    .MISS_W     (2),
    .MIN_GAP    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wdgIn       (wdgIn),
    .en          (en),
    .clrAlarm    (clrAlarm),
    .alarm       (alarm),
    .cause       (cause),
    .missCount   (missCount),
    .period      (period),
    .periodValid (periodValid)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic a, input logic [1:0] c,
                          input logic [1:0] m, input logic [7:0] p, input logic pv);
    checkOutput({tag, ".alarm"},       32'(alarm),       32'(a));
    checkOutput({tag, ".cause"},       32'(cause),       32'(c));
    checkOutput({tag, ".missCount"},   32'(missCount),   32'(m));
    checkOutput({tag, ".period"},      32'(period),      32'(p));
    checkOutput({tag, ".periodValid"}, 32'(periodValid), 32'(pv));
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    rst         = 1'b0;
    wdgIn       = 1'b1;
    en          = 1'b0;
    clrAlarm    = 1'b0;

    // Step 1: reset with heartbeat high, then release while disabled.
    applyStimulus(2);
    checkAll("reset", 1'b0, 2'b00, 2'd0, 8'd0, 1'b0);
    rst = 1'b1;
    applyStimulus(3);
    checkAll("idle_release", 1'b0, 2'b00, 2'd0, 8'd0, 1'b0);

    // Step 2: enable, then toggle every 10 cycles eight times.
    en = 1'b1;
    applyStimulus(1);
    for (int i = 0; i < 8; i++) begin
      wdgIn = ~wdgIn;
      for (int k = 0; k < 10; k++) begin
        applyStimulus(1);
        if (periodValid === 1'b1) pulses++;
      end
    end
    checkOutput("pv_pulses", 32'(pulses), 32'd7);
    checkAll("steady_run", 1'b0, 2'b00, 2'd0, 8'd10, 1'b0);

    // Step 3: heartbeat stops; last toggle was 9 edges ago.
    applyStimulus(10);
    checkOutput("miss_before_1", 32'(missCount), 32'd0);
    applyStimulus(1);
    checkOutput("miss_1", 32'(missCount), 32'd1);
    applyStimulus(19);
    checkOutput("miss_before_2", 32'(missCount), 32'd1);
    applyStimulus(1);
    checkOutput("miss_2", 32'(missCount), 32'd2);
    applyStimulus(19);
    checkOutput("alarm_before", 32'(alarm), 32'd0);
    applyStimulus(1);
    checkAll("timeout_alarm", 1'b1, 2'b01, 2'd3, 8'd10, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      wdgIn = ~wdgIn;
      for (int k = 0; k < 10; k++) begin
        applyStimulus(1);
        if (periodValid === 1'b1) pulses++;
      end
    end
    checkOutput("alarm_pv_pulses", 32'(pulses), 32'd0);
    checkAll("alarm_hold", 1'b1, 2'b01, 2'd3, 8'd10, 1'b0);

    // Step 4: clear alarm while enabled, re-arm, then toggle on cycle 20.
    clrAlarm = 1'b1;
    applyStimulus(1);
    clrAlarm = 1'b0;
    checkAll("clear", 1'b0, 2'b00, 2'd0, 8'd10, 1'b0);
    wdgIn = ~wdgIn;
    applyStimulus(1);
    checkOutput("arm_first_edge_pv", 32'(periodValid), 32'd0);
    applyStimulus(19);
    checkOutput("edge_wins_pre", 32'(missCount), 32'd0);
    wdgIn = ~wdgIn;
    applyStimulus(1);
    checkAll("edge_wins", 1'b0, 2'b00, 2'd0, 8'd20, 1'b1);

    // Step 5: next toggle arrives two cycles after the previous one.
    applyStimulus(1);
    wdgIn = ~wdgIn;
    applyStimulus(1);
`ifdef WDG_WINDOW_EN
    checkAll("early_toggle", 1'b1, 2'b10, 2'd0, 8'd2, 1'b0);
`else
    checkAll("short_toggle", 1'b0, 2'b00, 2'd0, 8'd2, 1'b1);
`endif

    // Step 6a: get into alarm (early fault or three timeouts), then reset.
    applyStimulus(65);
`ifdef WDG_WINDOW_EN
    checkOutput("alarm_pre_reset.cause", 32'(cause), 32'd2);
`else
    checkOutput("alarm_pre_reset.cause", 32'(cause), 32'd1);
`endif
    checkOutput("alarm_pre_reset.alarm", 32'(alarm), 32'd1);
    rst = 1'b0;
    applyStimulus(1);
    checkAll("reset_in_alarm", 1'b0, 2'b00, 2'd0, 8'd0, 1'b0);
    rst = 1'b1;

    // Step 6b: re-arm, build two misses, stray clear, then disable.
    applyStimulus(1);
    wdgIn = ~wdgIn;
    applyStimulus(1);
    applyStimulus(20);
    checkOutput("rerun_miss_1", 32'(missCount), 32'd1);
    clrAlarm = 1'b1;
    applyStimulus(1);
    clrAlarm = 1'b0;
    checkOutput("stray_clear_miss", 32'(missCount), 32'd1);
    applyStimulus(19);
    checkOutput("rerun_miss_2", 32'(missCount), 32'd2);
    en = 1'b0;
    applyStimulus(1);
    checkAll("disable", 1'b0, 2'b00, 2'd0, 8'd0, 1'b0);
    applyStimulus(25);
    checkAll("disabled_idle", 1'b0, 2'b00, 2'd0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
